// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/grant/data bundle between N requesters and the
// shared single-port RAM arbiter. Requester i owns slice i of each vector.
interface mem_arbiter_if #(
  parameter int AW = 13,
  parameter int DW = 8,
  parameter int N  = 2
);
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N-1:0]    lock;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-requester front end for a single-port synchronous RAM.
// One access per cycle, burst locking, registered one-cycle read return.
// Optional feature macro MEM_ARBITER_RR_EN: when defined, round-robin
// arbitration starting after the last granted index; when undefined,
// fixed priority where the lowest requesting index wins.
module mem_arbiter #(
  parameter int AW = 13,
  parameter int DW = 8,
  parameter int N  = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int IW = $clog2(N);

  logic [DW-1:0] mem [0:(2**AW)-1];

  logic          ownerValid_q, ownerValid_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [N-1:0]  rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q;

  logic          holdOwner;
  logic          gntAny;
  logic [IW-1:0] gntIdx;
  logic [N-1:0]  gntVec;
  logic          selWe;
  logic [AW-1:0] selAddr;
  logic [DW-1:0] selWdata;
  logic          fireRead;
  logic          fireWrite;

`ifdef MEM_ARBITER_RR_EN
  logic [IW-1:0] last_q, last_d;
`endif

  // A locked owner keeps the bus only while it still requests and still locks;
  // the first cycle either drops falls through to normal arbitration.
  assign holdOwner = ownerValid_q & bus.req[owner_q] & bus.lock[owner_q];

  // Pick the winning requester: locked owner first, otherwise the arbiter.
  always_comb begin
    gntAny = 1'b0;
    gntIdx = '0;
    if (holdOwner) begin
      gntAny = 1'b1;
      gntIdx = owner_q;
    end else begin
`ifdef MEM_ARBITER_RR_EN
      for (int k = 1; k <= N; k++) begin
        if (!gntAny && bus.req[(int'(last_q) + k) % N]) begin
          gntAny = 1'b1;
          gntIdx = IW'((int'(last_q) + k) % N);
        end
      end
`else
      for (int k = 0; k < N; k++) begin
        if (!gntAny && bus.req[k]) begin
          gntAny = 1'b1;
          gntIdx = IW'(k);
        end
      end
`endif
    end
  end

  // Expand the winner index into the one-hot grant seen by the requesters.
  always_comb begin
    gntVec = '0;
    if (gntAny) begin
      gntVec[gntIdx] = 1'b1;
    end
  end

  assign bus.gnt = gntVec;

  // Only the granted requester's controls reach the memory, so X on idle
  // requesters cannot leak into the array or the read register.
  assign selWe     = bus.we[gntIdx];
  assign selAddr   = bus.addr[gntIdx*AW +: AW];
  assign selWdata  = bus.wdata[gntIdx*DW +: DW];
  assign fireWrite = gntAny & selWe;
  assign fireRead  = gntAny & ~selWe;

  // Next-state for lock ownership, read-valid pulse and round-robin pointer.
  always_comb begin
    ownerValid_d = gntAny & bus.lock[gntIdx];
    owner_d      = ownerValid_d ? gntIdx : owner_q;
    rvalid_d     = fireRead ? gntVec : '0;
`ifdef MEM_ARBITER_RR_EN
    last_d       = gntAny ? gntIdx : last_q;
`endif
  end

  // Control state; reset makes index 0 the first winner and drops any burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ownerValid_q <= 1'b0;
      owner_q      <= '0;
      rvalid_q     <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_q       <= IW'(N - 1);
`endif
    end else begin
      ownerValid_q <= ownerValid_d;
      owner_q      <= owner_d;
      rvalid_q     <= rvalid_d;
`ifdef MEM_ARBITER_RR_EN
      last_q       <= last_d;
`endif
    end
  end

  // Registered read port; holds its value on idle and write cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (fireRead) begin
      rdata_q <= mem[selAddr];
    end
  end

  // Array write; contents survive reset, but an access racing reset is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
    end else if (fireWrite) begin
      mem[selAddr] <= selWdata;
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised multi-requester front end for a single-port synchronous RAM: the next generation of the shared VRAM/WRAM path, where the CPU, PPU fetcher and OAM DMA contend for the same array. One access per cycle is arbitrated among N requesters with req/gnt handshakes, optional burst locking and a registered one-cycle read return. The block instantiates its own storage and sits between the bus decoder and the memory.

## Interface
- AW, 13: address width; array depth is 2**AW.
- DW, 8: data width.
- N, 2: number of requesters (N >= 2); index 0 is highest initial priority.

- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  access request per requester.
- we  in  N  write enable per requester; sampled only when granted.
- lock  in  N  hold grant across consecutive cycles (burst).
- addr  in  N*AW  requester i address at [i*AW +: AW].
- wdata  in  N*DW  requester i write data at [i*DW +: DW].
- gnt  out  N  one-hot grant, combinational from req and internal state; all-zero when req is zero.
- rvalid  out  N  one-cycle pulse: read data for requester i is on rdata.
- rdata  out  DW  registered read data, shared by all requesters.

## Operation
- Each cycle at most one gnt bit is high; an access completes at the posedge where req[i] & gnt[i].
- Granted write: mem[addr_i] <= wdata_i at that edge; no rvalid.
- Granted read: rdata <= mem[addr_i], rvalid[i] <= 1 at that edge; all other rvalid bits 0.
- Cycle with no grant or a granted write: rvalid <= 0; rdata holds its last value.
- Arbitration (round-robin build): search starts at (last + 1) mod N, where last is the most recently granted index; first requester found wins. last updates on every grant.
- Lock: state owner_valid/owner. On a grant with lock[i]=1, owner <= i, owner_valid <= 1. While owner_valid and req[owner], gnt = owner regardless of other requests. owner_valid clears at any edge where req[owner]=0 or lock[owner]=0 (that cycle arbitrates normally).
- No reads and writes to the same address in one cycle exist (single port); read-after-write at the next cycle returns the new data.
- Memory contents are not reset and are not initialised.

## Timing
- Reset values: rvalid = 0, rdata = 0, last = N-1 (so index 0 wins first), owner_valid = 0, owner = 0; gnt = 0 while req = 0.
- Read latency: 1 cycle; data and rvalid valid in the cycle after the granted edge.
- Back-to-back reads by one locked requester: one result per cycle, rvalid held high across the burst.
- Requester dropping req while granted: gnt drops combinationally, no access occurs.
- rst asserted mid-burst: owner, last, rvalid, rdata cleared immediately (asynchronous); the in-flight access at that edge is discarded; memory retains prior writes.
- addr/we/wdata of non-granted requesters are ignored; X on them must not propagate to rdata or memory.

## Configuration
- MEM_ARBITER_RR_EN defined: round-robin arbitration as above, last register present.
- Not defined: fixed priority, lowest asserted index wins; last register removed; lock behaviour unchanged.

## Test plan
- Reset, N=2: req=2'b00 -> gnt=2'b00, rvalid=0, rdata=8'h00.
- Write: req0, we0, addr0=13'h0010, wdata0=8'hA5; next cycle read addr0=13'h0010 -> rvalid=2'b01 one cycle later, rdata=8'hA5.
- Contention (RR_EN): req=2'b11 held, both reads, 4 cycles -> gnt sequence 01,10,01,10; (macro off) gnt 01 every cycle.
- Lock burst: req1+lock1 reads addr 13'h0100..13'h0103 while req0 held high -> gnt=2'b10 for 4 cycles, rvalid=2'b10 continuous, rdata = preloaded bytes in order; lock1 drop -> next grant to requester 0.
- Async reset mid-burst: assert rst between edges during lock burst -> rvalid=0, rdata=0 immediately; after release req=2'b11 -> gnt=2'b01; earlier written 8'hA5 at 13'h0010 still reads back.
